user_clk_seq: RTL and testbench

USER_CLK_SEQ -- requirements
Module: user_clk_seq

---
 rtl/user_clk_seq.sv | 153 +++++++++++++++
 tb/tb_user_clk_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/user_clk_seq.sv
// Programmable user-clock sequencer: reset-pulse phase, optional fixed-length burst, graceful stop.
// Optional CLK_CE output (one cycle before each CLK_OUT rise) is enabled by defining USER_CLK_CE_OUT_EN.
module user_clk_seq #(
  parameter int HALF_DEF   = 25,
  parameter int RST_CYCLES = 5
) (
  input  logic        CLK_IN,
  input  logic        RST,
  input  logic        START,
  input  logic        STOP,
  input  logic [7:0]  HALF_IN,
  input  logic [15:0] BURST_LEN,
  output logic        CLK_OUT,
  output logic        RST_OUT,
  output logic        BUSY,
  output logic        DONE,
`ifdef USER_CLK_CE_OUT_EN
  output logic        CLK_CE,
`endif
  output logic [15:0] CYCLE_CNT
);

  typedef enum logic [1:0] {IDLE, RSTP, RUN, STOPW} state_t;

  localparam int             RPW     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [7:0]     HDEF    = 8'(HALF_DEF);
  localparam logic [RPW-1:0] RP_LAST = RPW'(RST_CYCLES - 1);

  state_t          state_q, state_d;
  logic [8:0]      cnt_q, cnt_d;
  logic [7:0]      h_q, h_d;
  logic [15:0]     n_q, n_d;
  logic [RPW-1:0]  rp_q, rp_d;
  logic [15:0]     cyc_q, cyc_d;
  logic            clk_out_q, clk_out_d;
  logic            rst_out_q, rst_out_d;
  logic            done_q, done_d;

  logic            wrap;
  logic [8:0]      cnt_adv;
  logic [15:0]     cyc_inc;

  assign wrap    = (cnt_q == ({h_q, 1'b0} - 9'd1));
  assign cnt_adv = wrap ? 9'd0 : cnt_q + 9'd1;
  assign cyc_inc = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    h_d       = h_q;
    n_d       = n_q;
    rp_d      = rp_q;
    cyc_d     = cyc_q;
    rst_out_d = rst_out_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 9'd0;
        if (START) begin
          h_d       = (HALF_IN < 8'd2) ? HDEF : HALF_IN;
          n_d       = BURST_LEN;
          rp_d      = '0;
          cyc_d     = 16'd0;
          rst_out_d = 1'b1;
          state_d   = RSTP;
        end
      end
      RSTP: begin
        cnt_d = cnt_adv;
        if (wrap) begin
          if (STOP) begin
            rst_out_d = 1'b0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else if (rp_q == RP_LAST) begin
            rst_out_d = 1'b0;
            state_d   = RUN;
          end else begin
            rp_d = rp_q + 1'b1;
          end
        end else if (STOP) begin
          state_d = STOPW;
        end
      end
      RUN: begin
        cnt_d = cnt_adv;
        if (wrap) begin
          cyc_d = cyc_inc;
          // A stop landing exactly on a period end finishes at that wrap.
          if (STOP || ((n_q != 16'd0) && (cyc_inc == n_q))) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else if (STOP) begin
          state_d = STOPW;
        end
      end
      STOPW: begin
        cnt_d = cnt_adv;
        if (wrap) begin
          // RST_OUT still high means the stop came from the reset-pulse phase.
          if (!rst_out_q) cyc_d = cyc_inc;
          rst_out_d = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign clk_out_d = (state_d != IDLE) && (cnt_d >= {1'b0, h_d});

  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= 9'd0;
      h_q       <= HDEF;
      n_q       <= 16'd0;
      rp_q      <= '0;
      cyc_q     <= 16'd0;
      clk_out_q <= 1'b0;
      rst_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      h_q       <= h_d;
      n_q       <= n_d;
      rp_q      <= rp_d;
      cyc_q     <= cyc_d;
      clk_out_q <= clk_out_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
    end
  end

`ifdef USER_CLK_CE_OUT_EN
  logic clk_ce_q;
  always_ff @(posedge CLK_IN) begin
    if (RST) clk_ce_q <= 1'b0;
    else     clk_ce_q <= (state_d != IDLE) && (cnt_d == ({1'b0, h_d} - 9'd1));
  end
  assign CLK_CE = clk_ce_q;
`endif

  assign CLK_OUT   = clk_out_q;
  assign RST_OUT   = rst_out_q;
  assign BUSY      = (state_q != IDLE);
  assign DONE      = done_q;
  assign CYCLE_CNT = cyc_q;

endmodule

// File: tb/tb_user_clk_seq.sv
// Directed bench for user_clk_seq: table of burst/stop scenarios plus hand-written reset and collision sequences.
module tb_user_clk_seq;

  logic        CLK_IN = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        STOP = 1'b0;
  logic [7:0]  HALF_IN = 8'd0;
  logic [15:0] BURST_LEN = 16'd0;
  logic        CLK_OUT, RST_OUT, BUSY, DONE;
  logic [15:0] CYCLE_CNT;
`ifdef USER_CLK_CE_OUT_EN
  logic        CLK_CE;
`endif

  user_clk_seq dut (
    .CLK_IN    (CLK_IN),
    .RST       (RST),
    .START     (START),
    .STOP      (STOP),
    .HALF_IN   (HALF_IN),
    .BURST_LEN (BURST_LEN),
    .CLK_OUT   (CLK_OUT),
    .RST_OUT   (RST_OUT),
    .BUSY      (BUSY),
    .DONE      (DONE),
`ifdef USER_CLK_CE_OUT_EN
    .CLK_CE    (CLK_CE),
`endif
    .CYCLE_CNT (CYCLE_CNT)
  );

  always #5 CLK_IN = ~CLK_IN;

  typedef struct {
    string       name;
    logic [7:0]  half;
    logic [15:0] burst;
    int          stop_k;    // cycle offset of STOP pulse; 0 = with START; -1 = none
    int          exp_done;  // cycle offset (from START cycle) of DONE
    int          exp_cnt;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic tick();
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int h, per, ph, ep, done_k, extra, bad, bad_k;
    logic eclk, erst, ebusy, ece, act_ce;
    int ecyc;
    h      = (v.half < 2) ? 25 : int'(v.half);
    per    = 2 * h;
    done_k = -1;
    extra  = 0;
    bad    = 0;
    bad_k  = -1;
    HALF_IN   = v.half;
    BURST_LEN = v.burst;
    START     = 1'b1;
    STOP      = (v.stop_k == 0);
    tick();
    START = 1'b0;
    STOP  = 1'b0;
    for (int k = 1; k <= v.exp_done + 6; k++) begin
      if (k < v.exp_done) begin
        ph    = (k - 1) % per;
        ep    = (k - 1) / per;
        eclk  = (ph >= h);
        erst  = (ep < 5);
        ebusy = 1'b1;
        ecyc  = (ep > 5) ? ep - 5 : 0;
        ece   = (ph == h - 1);
      end else begin
        eclk  = 1'b0;
        erst  = 1'b0;
        ebusy = 1'b0;
        ecyc  = v.exp_cnt;
        ece   = 1'b0;
      end
`ifdef USER_CLK_CE_OUT_EN
      act_ce = CLK_CE;
`else
      act_ce = ece;
`endif
      if (CLK_OUT !== eclk || RST_OUT !== erst || BUSY !== ebusy ||
          CYCLE_CNT !== 16'(ecyc) || act_ce !== ece) begin
        bad++;
        if (bad_k < 0) bad_k = k;
      end
      if (DONE === 1'b1) begin
        if (done_k < 0) done_k = k;
        else extra++;
      end
      // Ignored START pulses while busy, shifting inputs, and a STOP while idle.
      STOP      = (k == v.stop_k) || (k == v.exp_done + 2);
      START     = (k < v.exp_done) && (k % 37 == 0);
      HALF_IN   = 8'($urandom);
      BURST_LEN = 16'($urandom);
      tick();
    end
    START = 1'b0;
    STOP  = 1'b0;
    check({v.name, " done_cycle"}, done_k, v.exp_done);
    check({v.name, " cycle_cnt"}, {16'd0, CYCLE_CNT}, v.exp_cnt);
    check({v.name, " waveform_errs(first_k)"}, (bad == 0) ? 0 : bad_k, 0);
    check({v.name, " extra_done"}, extra, 0);
  endtask

  vec_t vecs[10];

  initial begin
    int k, extra_done;
    logic [31:0] cnt_bad;
    vecs[0] = '{"burst_h25_n3",     8'd25,  16'd3, -1, 401,  3};
    vecs[1] = '{"clamp_h1_n1",      8'd1,   16'd1, -1, 301,  1};
    vecs[2] = '{"clamp_h0_n1",      8'd0,   16'd1, -1, 301,  1};
    vecs[3] = '{"stop_run_p7",      8'd4,   16'd0, 91, 97,   7};
    vecs[4] = '{"burst_h2_n2",      8'd2,   16'd2, -1, 29,   2};
    vecs[5] = '{"stop_on_last",     8'd4,   16'd2, 56, 57,   2};
    vecs[6] = '{"stop_in_rstp",     8'd4,   16'd0, 10, 17,   0};
    vecs[7] = '{"stop_rstp_wrap",   8'd3,   16'd0, 6,  7,    0};
    vecs[8] = '{"stop_run_wrap",    8'd2,   16'd0, 24, 25,   1};
    vecs[9] = '{"start_stop_idle",  8'd3,   16'd1, 0,  37,   1};

    // Reset takes priority over START/STOP.
    RST = 1'b1; START = 1'b1; STOP = 1'b1;
    tick(); tick();
    check("reset_outputs", {11'd0, CLK_OUT, RST_OUT, BUSY, DONE, CYCLE_CNT, 1'b0}, 32'd0);
    RST = 1'b0; START = 1'b0; STOP = 1'b0;
    tick();
    check("idle_after_reset_busy", {31'd0, BUSY}, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Mid-run reset during the RSTP high phase, then a clean restart.
    HALF_IN = 8'd25; BURST_LEN = 16'd3; START = 1'b1;
    tick();
    START = 1'b0;
    for (k = 1; k < 30; k++) tick();
    check("rstp_high_phase", {30'd0, CLK_OUT, RST_OUT}, 32'd3);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("midrun_reset_outputs", {12'd0, CLK_OUT, RST_OUT, BUSY, DONE, CYCLE_CNT}, 32'd0);
    extra_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (DONE === 1'b1 || BUSY === 1'b1) extra_done++;
      tick();
    end
    check("midrun_reset_no_done", extra_done, 0);
    run_vec('{"restart_after_rst", 8'd2, 16'd1, -1, 25, 1});

    // START accepted in the same cycle DONE is high.
    HALF_IN = 8'd2; BURST_LEN = 16'd1; START = 1'b1;
    tick();
    START = 1'b0;
    k = 1;
    while (DONE !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    check("chain_first_done", k, 25);
    HALF_IN = 8'd3; BURST_LEN = 16'd1; START = 1'b1;
    tick();
    START = 1'b0;
    check("chain_restart_state", {28'd0, BUSY, RST_OUT, DONE, CLK_OUT}, 32'hC);
    k = 1;
    cnt_bad = 0;
    while (DONE !== 1'b1 && k < 200) begin
      if (CYCLE_CNT !== 16'd0) cnt_bad++;
      tick();
      k++;
    end
    check("chain_second_done", k, 37);
    check("chain_cnt_zero_in_rstp", cnt_bad, 0);
    check("chain_final_cnt", {16'd0, CYCLE_CNT}, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
